// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the posted-write store buffer.
// Entries are fixed at 32-bit address and data; the top narrows/widens at its ports.
package store_buffer_pkg;

    localparam int unsigned SB_ADDR_W        = 32;
    localparam int unsigned SB_DATA_W        = 32;
    localparam int unsigned SB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Pointer/count FIFO of store entries that exposes every slot and its valid bit
// so the parent can run a parallel address compare for load forwarding.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  sb_entry_t             push_entry_i,
    input  logic                  pop_i,
    output sb_entry_t             head_entry_o,
    output logic [PtrW-1:0]       head_ptr_o,
    output logic [PtrW:0]         count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output sb_entry_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]      valid_o
);

    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [PtrW:0]         count_q, count_d;
    sb_entry_t [DEPTH-1:0] mem_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; the valid bits derived from count guard every use.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    always_comb begin
        valid_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PtrW-1:0] age;
            age        = PtrW'(k) - head_q;
            valid_o[k] = ({1'b0, age} < count_q);
        end
    end

    assign head_entry_o = mem_q[head_q];
    assign head_ptr_o   = head_q;
    assign count_o      = count_q;
    assign full_o       = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign entries_o    = mem_q;

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and a valid/ready memory write port,
// with youngest-match store-to-load forwarding on word addresses.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = SB_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_valid_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic              mem_wvalid_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_wready_i,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    sb_entry_t             push_entry;
    sb_entry_t             head_entry;
    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PtrW-1:0]       head_ptr;
    logic [PtrW:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [SB_ADDR_W-1:0]  addr_ext;
    logic                  unused_ld_valid;

    // Loads need no gating: forwarding is a pure function of the presented address.
    assign unused_ld_valid = ld_valid_i;

    assign addr_ext        = SB_ADDR_W'(addr_i);
    assign push_entry.addr = addr_ext;
    assign push_entry.data = SB_DATA_W'(wdata_i);

    // No full bypass: a store arriving while full waits even if the head drains now.
    assign push = st_valid_i && !full;
    assign pop  = !empty && mem_wready_i;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .head_ptr_o   (head_ptr),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    assign stall_o      = st_valid_i && full;
    assign empty_o      = empty;
    assign mem_wvalid_o = !empty;
    assign mem_waddr_o  = ADDR_W'(head_entry.addr);
    assign mem_wdata_o  = DATA_W'(head_entry.data);
    assign mem_raddr_o  = addr_i;

    // Walk oldest to youngest so the last hit wins; count is implied by valid.
    always_comb begin
        rdata_o = mem_rdata_i;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PtrW-1:0] idx;
            idx = head_ptr + PtrW'(i);
            if (valid[idx] && (entries[idx].addr[SB_ADDR_W-1:2] == addr_ext[SB_ADDR_W-1:2])) begin
                rdata_o = DATA_W'(entries[idx].data);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with hand-computed expectations.
module tb_store_buffer;

    logic        clk_i;
    logic        rst_ni;
    logic        st_valid_i;
    logic        ld_valid_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        empty_o;
    logic        mem_wvalid_o;
    logic [31:0] mem_waddr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wready_i;
    logic [31:0] mem_raddr_o;
    logic [31:0] mem_rdata_i;

    int n_checks;
    int n_errors;

    store_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .st_valid_i   (st_valid_i),
        .ld_valid_i   (ld_valid_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .empty_o      (empty_o),
        .mem_wvalid_o (mem_wvalid_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wready_i (mem_wready_i),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so combinational outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_core();
        st_valid_i = 1'b0;
        ld_valid_i = 1'b0;
        addr_i     = '0;
        wdata_i    = '0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        st_valid_i = 1'b1;
        ld_valid_i = 1'b0;
        addr_i     = a;
        wdata_i    = d;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] memd);
        st_valid_i  = 1'b0;
        ld_valid_i  = 1'b1;
        addr_i      = a;
        mem_rdata_i = memd;
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_ni       = 1'b0;
        mem_wready_i = 1'b0;
        mem_rdata_i  = '0;
        idle_core();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Reset then idle
        check("rst_wvalid", {31'd0, mem_wvalid_o}, 32'd0);
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        do_load(32'h40, 32'hAAAA_0000);
        check("rst_load", rdata_o, 32'hAAAA_0000);
        check("raddr", mem_raddr_o, 32'h40);

        // Single store, forwarded to a load at a different byte of the same word
        do_store(32'h100, 32'h11);
        #1;
        check("st_no_fwd_same_cycle_wvalid", {31'd0, mem_wvalid_o}, 32'd0);
        tick();
        idle_core();
        #1;
        check("st1_wvalid", {31'd0, mem_wvalid_o}, 32'd1);
        check("st1_waddr", mem_waddr_o, 32'h100);
        check("st1_wdata", mem_wdata_o, 32'h11);
        check("st1_empty", {31'd0, empty_o}, 32'd0);
        do_load(32'h102, 32'hDEAD_BEEF);
        check("fwd_byte", rdata_o, 32'h11);
        do_load(32'h104, 32'hDEAD_BEEF);
        check("no_fwd_next_word", rdata_o, 32'hDEAD_BEEF);
        tick();
        check("hold_waddr", mem_waddr_o, 32'h100);
        check("hold_wdata", mem_wdata_o, 32'h11);
        mem_wready_i = 1'b1;
        tick();
        mem_wready_i = 1'b0;
        #1;
        check("st1_drained", {31'd0, empty_o}, 32'd1);

        // Two stores to one word: youngest forwarded, both drained in order
        do_store(32'h100, 32'h1);
        tick();
        do_store(32'h100, 32'h2);
        tick();
        do_load(32'h100, 32'h0BAD_0BAD);
        check("fwd_youngest", rdata_o, 32'h2);
        idle_core();
        mem_wready_i = 1'b1;
        #1;
        check("drain_first", mem_wdata_o, 32'h1);
        tick();
        check("drain_second", mem_wdata_o, 32'h2);
        check("drain_second_addr", mem_waddr_o, 32'h100);
        tick();
        mem_wready_i = 1'b0;
        #1;
        check("two_drained", {31'd0, empty_o}, 32'd1);

        // Fill, stall on fifth, no bypass when head drains the same cycle
        for (int i = 0; i < 4; i++) begin
            do_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            #1;
            check("fill_no_stall", {31'd0, stall_o}, 32'd0);
            tick();
        end
        do_store(32'h300, 32'hF5);
        #1;
        check("full_stall", {31'd0, stall_o}, 32'd1);
        tick();
        check("full_still_stall", {31'd0, stall_o}, 32'd1);
        check("full_head", mem_wdata_o, 32'hA0);
        mem_wready_i = 1'b1;
        #1;
        check("no_bypass_stall", {31'd0, stall_o}, 32'd1);
        tick();
        mem_wready_i = 1'b0;
        #1;
        check("after_pop_no_stall", {31'd0, stall_o}, 32'd0);
        check("after_pop_head", mem_wdata_o, 32'hA1);
        tick();
        idle_core();
        do_load(32'h300, 32'h0);
        check("fwd_fifth", rdata_o, 32'hF5);
        do_load(32'h208, 32'h0);
        check("fwd_mid_entry", rdata_o, 32'hA2);
        idle_core();
        mem_wready_i = 1'b1;
        #1;
        check("order_0", mem_wdata_o, 32'hA1);
        tick();
        check("order_1", mem_wdata_o, 32'hA2);
        tick();
        check("order_2", mem_wdata_o, 32'hA3);
        tick();
        check("order_3", mem_wdata_o, 32'hF5);
        check("order_3_addr", mem_waddr_o, 32'h300);
        tick();
        check("fill_drained", {31'd0, empty_o}, 32'd1);

        // Streaming with ready high: one in, one out each cycle, pointers wrap
        for (int i = 0; i < 7; i++) begin
            do_store(32'h400 + 32'(4 * i), 32'h50 + 32'(i));
            #1;
            check("stream_no_stall", {31'd0, stall_o}, 32'd0);
            if (i > 0) begin
                check("stream_head", mem_wdata_o, 32'h50 + 32'(i - 1));
            end
            tick();
            check("stream_nonempty", {31'd0, empty_o}, 32'd0);
        end
        idle_core();
        #1;
        check("stream_last", mem_wdata_o, 32'h56);
        tick();
        mem_wready_i = 1'b0;
        #1;
        check("stream_drained", {31'd0, empty_o}, 32'd1);

        // Reset discards pending stores
        for (int i = 0; i < 3; i++) begin
            do_store(32'h500 + 32'(4 * i), 32'hC0 + 32'(i));
            tick();
        end
        idle_core();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        check("rst2_wvalid", {31'd0, mem_wvalid_o}, 32'd0);
        check("rst2_empty", {31'd0, empty_o}, 32'd1);
        do_load(32'h504, 32'h1234_5678);
        check("rst2_load_mem", rdata_o, 32'h1234_5678);
        idle_core();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle core's data port and a data memory whose write port has a valid/ready handshake. Accepts one store per cycle into a DEPTH-entry FIFO, drains entries to memory in program order, and forwards the youngest buffered store data to same-word loads so the core always reads coherent data. Asserts `stall_o` only when a store arrives while the buffer is full.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width; stores are full-word only

- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  reset, synchronous, active-low
- `st_valid_i`  in  1  core store request (core `memwrite`)
- `ld_valid_i`  in  1  core load request; never high together with `st_valid_i`
- `addr_i`  in  ADDR_W  core byte address (core ALU result)
- `wdata_i`  in  DATA_W  core store data
- `rdata_o`  out  DATA_W  load data to core, combinational
- `stall_o`  out  1  core must hold the current instruction
- `empty_o`  out  1  no buffered stores
- `mem_wvalid_o`  out  1  head entry offered to memory
- `mem_waddr_o`  out  ADDR_W  head entry address
- `mem_wdata_o`  out  DATA_W  head entry data
- `mem_wready_i`  in  1  memory accepts head this cycle
- `mem_raddr_o`  out  ADDR_W  memory read address, equals `addr_i`
- `mem_rdata_i`  in  DATA_W  memory read data, combinational

## Operation
- State: entry array {addr, data}, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (log2 DEPTH + 1 bits).
- Enqueue: `st_valid_i && count < DEPTH` writes {addr_i, wdata_i} at tail; tail+1.
- Full: `stall_o = st_valid_i && count == DEPTH`; no enqueue that cycle. No full bypass: a dequeue in the same cycle does not admit the store; it enqueues next cycle.
- Dequeue: `mem_wvalid_o = count != 0`; `mem_waddr_o`/`mem_wdata_o` from head. On `mem_wvalid_o && mem_wready_i` head+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Head entry must stay stable while `mem_wvalid_o && !mem_wready_i`.
- Load forwarding: compare `addr_i[ADDR_W-1:2]` against every valid entry; if any match, `rdata_o` = data of the youngest (closest to tail) match; else `rdata_o = mem_rdata_i`. The head entry being dequeued this cycle still counts as valid for forwarding.
- Low two address bits are ignored for matching and passed unchanged to memory.
- `empty_o = count == 0`.
- Reset (`!rst_ni` at an edge): pointers and count to 0; entries need no reset. Pending stores are discarded, including mid-handshake.

## Timing
- After reset: `mem_wvalid_o = 0`, `empty_o = 1`, `stall_o = 0`, `mem_waddr_o`/`mem_wdata_o` don't-care; `rdata_o` follows `mem_rdata_i`.
- Store accepted at edge N is offered at `mem_wvalid_o` from cycle N+1 at earliest, and is forwardable to loads from cycle N+1.
- Throughput: one store enqueue and one drain per cycle.
- `stall_o`, `rdata_o`, `mem_raddr_o` are combinational from inputs and registered state; all other outputs depend only on registered state.
- Drain order equals enqueue order; no reordering or merging.

## Structure
- Package `store_buffer_pkg`: `sb_entry_t` struct {addr, data}, parameterised by ADDR_W and DATA_W (or fixed 32/32 as package constants), plus `SB_DEPTH_DEFAULT`.
- Sub-module `sb_fifo`: pointer/count FIFO of `sb_entry_t` exposing all entries and valid bits for the forwarding compare.
- Youngest-match priority select lives in `store_buffer`.

## Test plan
- Reset then idle: `mem_wvalid_o=0`, `empty_o=1`; load 0x40 with `mem_rdata_i=0xAAAA0000` gives `rdata_o=0xAAAA0000`.
- Store 0x100←0x11, `mem_wready_i=0`: next cycle `mem_wvalid_o=1`, `mem_waddr_o=0x100`; load 0x102 returns 0x11, not memory data.
- Stores 0x100←1, 0x100←2 buffered: load 0x100 returns 2; release ready for 2 cycles: memory sees 1 then 2, then `empty_o=1`.
- Four stores with `mem_wready_i=0`, fifth store: `stall_o=1`, count stays 4; raise ready for one cycle: fifth still stalled that cycle, accepted the next.
- Continuous stores with `mem_wready_i=1`: one enqueue and one drain per cycle, count stays 1, wrap past DEPTH preserves order.
- Three stores buffered, `rst_ni=0` for one edge: `mem_wvalid_o=0`, `empty_o=1` next cycle; earlier address loads return `mem_rdata_i`.
